mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  EX/MEM pipeline register, data-memory access, branch resolution and MEM/WB pipeline register, in one block.
//  Consumes the execute-stage outputs: ALU result, zero flag, store data, branch target, destination register.
//  Produces the PC-select/target back to fetch and the registered write-back bundle for the register file.
// PARAMETERS
//  DATA_W   32   datapath / memory word width
//  DEPTH    256  data-memory depth in words (power of 2); index = ALU result[log2(DEPTH)+1:2]
//  RADDR_W  5    register-file address width
// PORTS
//  clk            in   1        clock, rising edge
//  rst_n          in   1        asynchronous reset, active low
//  stall          in   1        1 = hold both pipeline registers; no memory write
//  flush          in   1        1 = squash instruction entering EX/MEM (bubble)
//  ex_valid       in   1        execute-stage instruction is valid
//  ex_alu_result  in   DATA_W   ALU result / memory byte address
//  ex_zero        in   1        ALU zero flag
//  ex_wdata       in   DATA_W   store data (rt register value)
//  ex_target      in   DATA_W   branch target address
//  ex_regdesti    in   RADDR_W  destination register
//  ex_memread     in   1        load
//  ex_memwrite    in   1        store
//  ex_branch      in   1        branch-on-equal
//  ex_regwrite    in   1        writes register file
//  ex_memtoreg    in   1        write-back selects memory data
//  pc_src         out  1        take branch (to fetch)
//  branch_target  out  DATA_W   target for taken branch
//  wb_valid       out  1        MEM/WB entry valid
//  wb_regwrite    out  1        register-file write enable
//  wb_memtoreg    out  1        write-back mux select
//  wb_read_data   out  DATA_W   loaded word
//  wb_alu_result  out  DATA_W   ALU result passed through
//  wb_regdesti    out  RADDR_W  destination register
//  misalign_err   out  1        MEM/WB entry had a misaligned load/store
//  load_cnt       out  16       retired loads (MEM_ACCESS_CNT_EN)
//  store_cnt      out  16       retired stores (MEM_ACCESS_CNT_EN)
// BEHAVIOUR
//  - Reset: all EX/MEM and MEM/WB fields, all outputs and counters are 0 immediately (async). Memory array is not reset.
//  - Timing: ex_* presented in cycle N, stall=0 -> captured into EX/MEM at edge N.
//    pc_src and branch_target are valid during N+1, combinational from EX/MEM.
//    Captured into MEM/WB at edge N+1; wb_* are valid during N+2.
//  - EX/MEM update per edge, in priority order:
//    - flush=1: mem_valid<=0; other fields don't-care, implementation zeroes them. Flush overrides stall.
//    - else stall=1: hold.
//    - else: capture ex_*.
//  - MEM/WB update per edge:
//    - stall=1: hold.
//    - else: capture the EX/MEM content plus read data.
//  - pc_src = mem_valid & mem_branch & mem_zero. branch_target = mem_target, always driven.
//  - Hazard unit: when pc_src=1 it must drive flush in the same cycle. This block does not self-flush.
//  - Alignment: aligned = (mem_alu_result[1:0]==2'b00). Upper address bits beyond the index wrap (modulo DEPTH).
//  - Store: mem[idx]<=mem_wdata at the edge where mem_valid & mem_memwrite & aligned & !stall.
//    Exactly one write per instruction, however long it stalls.
//  - Load read: asynchronous array read at idx, registered into wb_read_data.
//    A store and a load to the same index in consecutive instructions: the load sees the new data.
//  - Invalid or non-load entry: wb_read_data captures 0.
//  - Misaligned load or store (valid entry): store suppressed; wb_read_data=0; wb_regwrite forced 0; misalign_err=1 for that entry.
//  - wb_regwrite = mem_valid & mem_regwrite & !(misaligned access). wb_valid = mem_valid.
//  - Reset asserted mid-stall or mid-branch: state clears at once. pc_src drops to 0 without waiting for a clock.
// CONFIGURATION
//  MEM_ACCESS_CNT_EN defined:
//    - load_cnt / store_cnt increment at each edge where a valid, aligned load/store advances (stall=0).
//    - Counters saturate at 16'hFFFF; reset to 0.
//  MEM_ACCESS_CNT_EN undefined: load_cnt and store_cnt are tied to 0 and no counter logic is built.
// TESTING
//  1 Store 0xDEADBEEF @0x10, next cycle load @0x10 -> wb_read_data=0xDEADBEEF, wb_regwrite=1, wb_memtoreg=1, 2 cycles after load presented.
//  2 branch=1, zero=1, target=0x40 -> pc_src=1, branch_target=0x40 in next cycle.
//    Same with zero=0 -> pc_src=0. Same with ex_valid=0 -> pc_src=0.
//  3 Store 0x1234 @0x20 held in EX/MEM by stall=1 for 3 cycles, inputs toggled meanwhile -> wb_* unchanged.
//    Memory written once after release; later load @0x20 returns 0x1234.
//  4 flush=1 and stall=1 in same cycle with a valid load -> next cycle pc_src=0; two cycles later wb_valid=0, wb_regwrite=0.
//  5 Store 0xAAAA @0x12 (misaligned) after store 0x5555 @0x10 -> misalign_err=1 for it.
//    Load @0x10 returns 0x5555. Misaligned load @0x13 -> wb_read_data=0, wb_regwrite=0.
//  6 rst_n low mid-stream (between edges) -> all outputs 0 immediately.
//    With MEM_ACCESS_CNT_EN, 3 loads + 2 stores after reset -> load_cnt=3, store_cnt=2.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM pipeline register, data-memory access, branch resolution
// and MEM/WB pipeline register.
// Optional feature macro: MEM_ACCESS_CNT_EN builds saturating retired
// load/store counters. Without it, load_cnt/store_cnt are tied to zero.
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               ex_valid,
  input  logic [DATA_W-1:0]  ex_alu_result,
  input  logic               ex_zero,
  input  logic [DATA_W-1:0]  ex_wdata,
  input  logic [DATA_W-1:0]  ex_target,
  input  logic [RADDR_W-1:0] ex_regdesti,
  input  logic               ex_memread,
  input  logic               ex_memwrite,
  input  logic               ex_branch,
  input  logic               ex_regwrite,
  input  logic               ex_memtoreg,
  output logic               pc_src,
  output logic [DATA_W-1:0]  branch_target,
  output logic               wb_valid,
  output logic               wb_regwrite,
  output logic               wb_memtoreg,
  output logic [DATA_W-1:0]  wb_read_data,
  output logic [DATA_W-1:0]  wb_alu_result,
  output logic [RADDR_W-1:0] wb_regdesti,
  output logic               misalign_err,
  output logic [15:0]        load_cnt,
  output logic [15:0]        store_cnt
);

  localparam int IDX_W = $clog2(DEPTH);

  // EX/MEM register fields
  logic               mem_valid_q;
  logic [DATA_W-1:0]  mem_alu_q;
  logic               mem_zero_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic [DATA_W-1:0]  mem_target_q;
  logic [RADDR_W-1:0] mem_rd_q;
  logic               mem_memread_q;
  logic               mem_memwrite_q;
  logic               mem_branch_q;
  logic               mem_regwrite_q;
  logic               mem_memtoreg_q;

  // MEM/WB register fields
  logic               wb_valid_q;
  logic               wb_regwrite_q;
  logic               wb_memtoreg_q;
  logic [DATA_W-1:0]  wb_read_data_q;
  logic [DATA_W-1:0]  wb_alu_q;
  logic [RADDR_W-1:0] wb_rd_q;
  logic               misalign_q;

  // Next-state values for the MEM/WB fields that need computing
  logic               wb_regwrite_d;
  logic [DATA_W-1:0]  wb_read_data_d;
  logic               misalign_d;

  // Data memory (not reset) and access decode
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [IDX_W-1:0]   idx_s;
  logic               aligned_s;
  logic               access_s;
  logic               do_store_s;

  assign idx_s      = mem_alu_q[IDX_W+1:2];
  assign aligned_s  = (mem_alu_q[1:0] == 2'b00);
  assign access_s   = mem_valid_q & (mem_memread_q | mem_memwrite_q);
  assign do_store_s = mem_valid_q & mem_memwrite_q & aligned_s & ~stall;

  // Branch resolution straight from EX/MEM so reset drops pc_src at once
  assign pc_src        = mem_valid_q & mem_branch_q & mem_zero_q;
  assign branch_target = mem_target_q;

  // EX/MEM: flush squashes (beats stall), stall holds, otherwise capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      mem_valid_q    <= 1'b0;
      mem_alu_q      <= '0;
      mem_zero_q     <= 1'b0;
      mem_wdata_q    <= '0;
      mem_target_q   <= '0;
      mem_rd_q       <= '0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_branch_q   <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
    end else if (!stall) begin
      mem_valid_q    <= ex_valid;
      mem_alu_q      <= ex_alu_result;
      mem_zero_q     <= ex_zero;
      mem_wdata_q    <= ex_wdata;
      mem_target_q   <= ex_target;
      mem_rd_q       <= ex_regdesti;
      mem_memread_q  <= ex_memread;
      mem_memwrite_q <= ex_memwrite;
      mem_branch_q   <= ex_branch;
      mem_regwrite_q <= ex_regwrite;
      mem_memtoreg_q <= ex_memtoreg;
    end
  end

  // Store port: one write, on the edge where the store leaves EX/MEM
  always_ff @(posedge clk) begin
    if (do_store_s) begin
      mem_q[idx_s] <= mem_wdata_q;
    end
  end

  // Write-back bundle: async read, misalignment kills data and regwrite
  always_comb begin
    wb_read_data_d = '0;
    misalign_d     = access_s & ~aligned_s;
    wb_regwrite_d  = mem_valid_q & mem_regwrite_q & ~misalign_d;
    if (mem_valid_q && mem_memread_q && aligned_s) begin
      wb_read_data_d = mem_q[idx_s];
    end else begin
      wb_read_data_d = '0;
    end
  end

  // MEM/WB: hold under stall, otherwise advance the EX/MEM entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q     <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_memtoreg_q  <= 1'b0;
      wb_read_data_q <= '0;
      wb_alu_q       <= '0;
      wb_rd_q        <= '0;
      misalign_q     <= 1'b0;
    end else if (!stall) begin
      wb_valid_q     <= mem_valid_q;
      wb_regwrite_q  <= wb_regwrite_d;
      wb_memtoreg_q  <= mem_memtoreg_q;
      wb_read_data_q <= wb_read_data_d;
      wb_alu_q       <= mem_alu_q;
      wb_rd_q        <= mem_rd_q;
      misalign_q     <= misalign_d;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_regwrite   = wb_regwrite_q;
  assign wb_memtoreg   = wb_memtoreg_q;
  assign wb_read_data  = wb_read_data_q;
  assign wb_alu_result = wb_alu_q;
  assign wb_regdesti   = wb_rd_q;
  assign misalign_err  = misalign_q;

`ifdef MEM_ACCESS_CNT_EN
  logic [15:0] load_cnt_q;
  logic [15:0] store_cnt_q;

  // Saturating counts of aligned loads/stores retiring out of EX/MEM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q  <= 16'h0000;
      store_cnt_q <= 16'h0000;
    end else if (!stall && mem_valid_q && aligned_s) begin
      if (mem_memread_q && (load_cnt_q != 16'hFFFF)) begin
        load_cnt_q <= load_cnt_q + 16'h0001;
      end
      if (mem_memwrite_q && (store_cnt_q != 16'hFFFF)) begin
        store_cnt_q <= store_cnt_q + 16'h0001;
      end
    end
  end

  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;
`else
  assign load_cnt  = 16'h0000;
  assign store_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver pushes the expected write-back
// bundle of every instruction that enters the pipe; the monitor pops and
// compares each time a new valid MEM/WB entry appears.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic        ex_valid, ex_zero;
  logic [31:0] ex_alu_result, ex_wdata, ex_target;
  logic [4:0]  ex_regdesti;
  logic        ex_memread, ex_memwrite, ex_branch, ex_regwrite, ex_memtoreg;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        wb_valid, wb_regwrite, wb_memtoreg;
  logic [31:0] wb_read_data, wb_alu_result;
  logic [4:0]  wb_regdesti;
  logic        misalign_err;
  logic [15:0] load_cnt, store_cnt;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_zero(ex_zero),
    .ex_wdata(ex_wdata), .ex_target(ex_target), .ex_regdesti(ex_regdesti),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .pc_src(pc_src), .branch_target(branch_target),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result),
    .wb_regdesti(wb_regdesti), .misalign_err(misalign_err),
    .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic        mis;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [256];
  int          checks = 0;
  int          errors = 0;
  logic        adv_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Remember whether the last edge let MEM/WB advance
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) adv_r <= 1'b0;
    else        adv_r <= ~stall;
  end

  // Monitor: compare each newly presented valid write-back entry
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && adv_r && wb_valid) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_entry", 32'(wb_alu_result), 32'hFFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        check("wb_regwrite",  32'(wb_regwrite),  32'(e.rw));
        check("wb_memtoreg",  32'(wb_memtoreg),  32'(e.m2r));
        check("misalign_err", 32'(misalign_err), 32'(e.mis));
        check("wb_read_data", wb_read_data,      e.rdata);
        check("wb_alu_result", wb_alu_result,    e.alu);
        check("wb_regdesti",  32'(wb_regdesti),  32'(e.rd));
      end
    end
  end

  // Drive one cycle of EX inputs; queue the expected result if it enters
  task automatic issue(input logic v, input logic [31:0] alu, input logic z,
                       input logic [31:0] wd, input logic [31:0] tg, input logic [4:0] rd,
                       input logic mr, input logic mw, input logic br, input logic rw,
                       input logic m2r, input logic st, input logic fl);
    exp_t e;
    logic al, mis;
    ex_valid = v; ex_alu_result = alu; ex_zero = z; ex_wdata = wd; ex_target = tg;
    ex_regdesti = rd; ex_memread = mr; ex_memwrite = mw; ex_branch = br;
    ex_regwrite = rw; ex_memtoreg = m2r; stall = st; flush = fl;
    if (v && !st && !fl) begin
      al  = (alu[1:0] == 2'b00);
      mis = (mr | mw) & ~al;
      e.rw    = rw & ~mis;
      e.m2r   = m2r;
      e.mis   = mis;
      e.rdata = (mr && al) ? model[alu[9:2]] : 32'h0;
      e.alu   = alu;
      e.rd    = rd;
      if (mw && al) model[alu[9:2]] = wd;
      sbq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic bub(input logic fl);
    issue(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fl);
  endtask

  task automatic ld(input logic [31:0] a, input logic [4:0] rd);
    issue(1'b1, a, 1'b0, 32'h0, 32'h0, rd, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic sto(input logic [31:0] a, input logic [31:0] d);
    issue(1'b1, a, 1'b0, d, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_zero = 1'b0;
    ex_alu_result = 32'h0; ex_wdata = 32'h0; ex_target = 32'h0; ex_regdesti = 5'd0;
    ex_memread = 1'b0; ex_memwrite = 1'b0; ex_branch = 1'b0;
    ex_regwrite = 1'b0; ex_memtoreg = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc_src", 32'(pc_src), 32'h0);
    check("rst_wb_valid", 32'(wb_valid), 32'h0);
    check("rst_branch_target", branch_target, 32'h0);
    rst_n = 1'b1;
    bub(1'b0);

    // 1: store then dependent load
    sto(32'h10, 32'hDEADBEEF);
    ld(32'h10, 5'd1);
    bub(1'b0);
    check("t1_read_data", wb_read_data, 32'hDEADBEEF);
    check("t1_regwrite", 32'(wb_regwrite), 32'h1);
    check("t1_memtoreg", 32'(wb_memtoreg), 32'h1);

    // 2: branch resolution
    issue(1'b1, 32'h0, 1'b1, 32'h0, 32'h40, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_taken_pc_src", 32'(pc_src), 32'h1);
    check("t2_taken_target", branch_target, 32'h40);
    bub(1'b1);
    issue(1'b1, 32'h1, 1'b0, 32'h0, 32'h40, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_nz_pc_src", 32'(pc_src), 32'h0);
    check("t2_nz_target", branch_target, 32'h40);
    issue(1'b0, 32'h0, 1'b1, 32'h0, 32'h40, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_inv_pc_src", 32'(pc_src), 32'h0);
    bub(1'b0);

    // 3: store held by stall, inputs toggling meanwhile
    issue(1'b1, 32'h77, 1'b0, 32'h0, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    sto(32'h20, 32'h1234);
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 32'h20 + 32'(i), 1'(i), 32'hFFFF_0000 + 32'(i), 32'h100, 5'(i + 7),
            1'(i), 1'b1, 1'(i), 1'b1, 1'b1, 1'b1, 1'b0);
      check("t3_hold_alu", wb_alu_result, 32'h77);
      check("t3_hold_rd", 32'(wb_regdesti), 32'd3);
    end
    ld(32'h20, 5'd4);
    bub(1'b0);

    // 4: flush and stall together on a valid load
    issue(1'b1, 32'h10, 1'b1, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("t4_pc_src", 32'(pc_src), 32'h0);
    bub(1'b0);
    bub(1'b0);
    check("t4_wb_valid", 32'(wb_valid), 32'h0);
    check("t4_wb_regwrite", 32'(wb_regwrite), 32'h0);

    // 5: misaligned store and load
    sto(32'h10, 32'h5555);
    sto(32'h12, 32'hAAAA);
    ld(32'h10, 5'd5);
    ld(32'h13, 5'd6);
    bub(1'b0);
    bub(1'b0);
    check("t5_mis_read_data", wb_read_data, 32'h0);
    check("t5_mis_regwrite", 32'(wb_regwrite), 32'h0);

    // 6: reset between edges with a taken branch in EX/MEM
    issue(1'b1, 32'h0, 1'b1, 32'h0, 32'h80, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t6_pre_pc_src", 32'(pc_src), 32'h1);
    #2 rst_n = 1'b0;
    sbq.delete();
    #1;
    check("t6_pc_src", 32'(pc_src), 32'h0);
    check("t6_branch_target", branch_target, 32'h0);
    check("t6_wb_valid", 32'(wb_valid), 32'h0);
    check("t6_wb_alu", wb_alu_result, 32'h0);
    check("t6_wb_read_data", wb_read_data, 32'h0);
    check("t6_cnts", {load_cnt, store_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ld(32'h10, 5'd1);
    ld(32'h20, 5'd2);
    sto(32'h30, 32'h1);
    ld(32'h10, 5'd3);
    sto(32'h34, 32'h2);
    sto(32'h36, 32'h3);
    ld(32'h31, 5'd4);
    bub(1'b0);
    bub(1'b0);
`ifdef MEM_ACCESS_CNT_EN
    check("t6_load_cnt", 32'(load_cnt), 32'd3);
    check("t6_store_cnt", 32'(store_cnt), 32'd2);
`else
    check("t6_load_cnt", 32'(load_cnt), 32'd0);
    check("t6_store_cnt", 32'(store_cnt), 32'd0);
`endif
    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
